// File: rtl/mips_pkg.sv
// Shared types and constants for the program-counter sequencer and its next-PC mux.
package mips_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } seq_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INC_DEFAULT      = 4;
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC priority select: branch > jump > stall > increment in RUN,
// hold or single-step in HALT. Also reports redirect and misaligned-target flags.
module pc_next_mux
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int INC   = INC_DEFAULT
) (
  input  logic [WIDTH-1:0] pc,
  input  seq_state_e       state,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             step,
  input  logic             resume,
  output logic [WIDTH-1:0] pc_next,
  output logic             redirect,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] MASK = {{(WIDTH-2){1'b1}}, 2'b00};

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] target;

  assign pc_inc = pc + WIDTH'(INC);

  always_comb begin
    pc_next  = pc_inc;
    target   = '0;
    redirect = 1'b0;
    misalign = 1'b0;
    if (state == HALT) begin
      // Redirects and stalls are ignored while halted; resume beats step.
      pc_next = (step && !resume) ? pc_inc : pc;
    end else if (branch_taken) begin
      target   = branch_target;
      redirect = 1'b1;
    end else if (jump) begin
      target   = jump_target;
      redirect = 1'b1;
    end else if (stall) begin
      pc_next = pc;
    end
    if (redirect) begin
      pc_next  = target & MASK;
      misalign = is_misaligned(target[1:0]);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: holds the PC and RUN/HALT state, issues one-cycle
// IF/ID flush and misalign pulses on redirects, and gates fetch validity.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
  parameter int               INC      = INC_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             STALL,
  input  logic             BRANCH_TAKEN,
  input  logic [WIDTH-1:0] BRANCH_TARGET,
  input  logic             JUMP,
  input  logic [WIDTH-1:0] JUMP_TARGET,
  input  logic             HALT_REQ,
  input  logic             STEP,
  input  logic             RESUME,
  output logic [WIDTH-1:0] PC_OUT,
  output logic [WIDTH-1:0] PC_PLUS4,
  output logic             FETCH_VALID,
  output logic             FLUSH,
  output logic             HALTED,
  output logic             MISALIGN
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             first_q, first_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;
  logic             step_valid_q, step_valid_d;

  logic [WIDTH-1:0] pc_next;
  logic             redirect;
  logic             target_misaligned;

  pc_next_mux #(
    .WIDTH(WIDTH),
    .INC  (INC)
  ) u_next_mux (
    .pc           (pc_q),
    .state        (state_q),
    .stall        (STALL),
    .branch_taken (BRANCH_TAKEN),
    .branch_target(BRANCH_TARGET),
    .jump         (JUMP),
    .jump_target  (JUMP_TARGET),
    .step         (STEP),
    .resume       (RESUME),
    .pc_next      (pc_next),
    .redirect     (redirect),
    .misalign     (target_misaligned)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_next;
    first_d      = 1'b0;
    flush_d      = 1'b0;
    misalign_d   = 1'b0;
    step_valid_d = 1'b0;
    case (state_q)
      RUN: begin
        flush_d    = redirect;
        misalign_d = target_misaligned;
        if (HALT_REQ) begin
          state_d = HALT;
        end
      end
      HALT: begin
        // A fresh halt request pins the sequencer in HALT even against resume.
        if (RESUME && !HALT_REQ) begin
          state_d = RUN;
        end else if (STEP && !RESUME) begin
          step_valid_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      first_q      <= 1'b1;
      flush_q      <= 1'b0;
      misalign_q   <= 1'b0;
      step_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      first_q      <= first_d;
      flush_q      <= flush_d;
      misalign_q   <= misalign_d;
      step_valid_q <= step_valid_d;
    end
  end

  always_comb begin
    FETCH_VALID = 1'b0;
    if (state_q == HALT) begin
      FETCH_VALID = step_valid_q;
    end else begin
      FETCH_VALID = !first_q && (!STALL || redirect);
    end
  end

  assign PC_OUT   = pc_q;
  assign PC_PLUS4 = pc_q + WIDTH'(INC);
  assign FLUSH    = flush_q;
  assign HALTED   = (state_q == HALT);
  assign MISALIGN = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: per-scenario tasks drive a cycle table, push the
// expected visible outputs to a queue and pop/compare them mid-cycle.
module tb_pc_sequencer;

  localparam int W = 68;

  // control word bits: {rst, stall, branch, jump, halt_req, step, resume}
  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_RST   = 7'b1000000;
  localparam logic [6:0] C_STALL = 7'b0100000;
  localparam logic [6:0] C_BR    = 7'b0010000;
  localparam logic [6:0] C_JMP   = 7'b0001000;
  localparam logic [6:0] C_HREQ  = 7'b0000100;
  localparam logic [6:0] C_STEP  = 7'b0000010;
  localparam logic [6:0] C_RES   = 7'b0000001;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = '0;
  logic        JUMP = 1'b0;
  logic [31:0] JUMP_TARGET = '0;
  logic        HALT_REQ = 1'b0;
  logic        STEP = 1'b0;
  logic        RESUME = 1'b0;
  logic [31:0] PC_OUT;
  logic [31:0] PC_PLUS4;
  logic        FETCH_VALID;
  logic        FLUSH;
  logic        HALTED;
  logic        MISALIGN;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer dut (
    .CLK          (CLK),
    .RST          (RST),
    .STALL        (STALL),
    .BRANCH_TAKEN (BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET),
    .JUMP         (JUMP),
    .JUMP_TARGET  (JUMP_TARGET),
    .HALT_REQ     (HALT_REQ),
    .STEP         (STEP),
    .RESUME       (RESUME),
    .PC_OUT       (PC_OUT),
    .PC_PLUS4     (PC_PLUS4),
    .FETCH_VALID  (FETCH_VALID),
    .FLUSH        (FLUSH),
    .HALTED       (HALTED),
    .MISALIGN     (MISALIGN)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] e(input logic [31:0] pc, input logic fv, input logic fl,
                                     input logic h, input logic m);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    return {pc, p4, fv, fl, h, m};
  endfunction

  function automatic logic [W-1:0] observed();
    return {PC_OUT, PC_PLUS4, FETCH_VALID, FLUSH, HALTED, MISALIGN};
  endfunction

  // driver tasks
  task automatic apply(input logic [6:0] c, input logic [31:0] bt, input logic [31:0] jt);
    {RST, STALL, BRANCH_TAKEN, JUMP, HALT_REQ, STEP, RESUME} = c;
    BRANCH_TARGET = bt;
    JUMP_TARGET   = jt;
  endtask

  task automatic do_reset();
    apply(C_RST, 32'h0, 32'h0);
    @(posedge CLK);
    #1;
    apply(C_IDLE, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    logic [W-1:0] want;
    logic [31:0] pcs [4];
    pcs = '{32'd0, 32'd4, 32'd8, 32'd12};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(C_IDLE, 32'h0, 32'h0);
      exp_q.push_back(e(pcs[i], (i != 0), 1'b0, 1'b0, 1'b0));
      @(negedge CLK);
      want = exp_q.pop_front();
      n_checks++;
      if (observed() !== want) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got=%h expected=%h", i, observed(), want);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_branch_stall();
    logic [W-1:0] want;
    logic [6:0]   ctl [5];
    logic [W-1:0] ex  [5];
    ctl = '{C_IDLE, C_IDLE, C_BR | C_STALL, C_IDLE, C_IDLE};
    ex  = '{e(32'd0, 0, 0, 0, 0), e(32'd4, 1, 0, 0, 0), e(32'd8, 1, 0, 0, 0),
            e(32'h100, 1, 1, 0, 0), e(32'h104, 1, 0, 0, 0)};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(ctl[i], 32'h100, 32'h0);
      exp_q.push_back(ex[i]);
      @(negedge CLK);
      want = exp_q.pop_front();
      n_checks++;
      if (observed() !== want) begin
        n_fail++;
        $display("FAIL branch_stall[%0d]: got=%h expected=%h", i, observed(), want);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_branch_jump();
    logic [W-1:0] want;
    logic [6:0]   ctl [6];
    logic [31:0]  jt  [6];
    logic [W-1:0] ex  [6];
    ctl = '{C_IDLE, C_BR | C_JMP, C_IDLE, C_JMP, C_IDLE, C_IDLE};
    jt  = '{32'h0, 32'h80, 32'h0, 32'h82, 32'h0, 32'h0};
    ex  = '{e(32'd0, 0, 0, 0, 0), e(32'd4, 1, 0, 0, 0), e(32'h40, 1, 1, 0, 0),
            e(32'h44, 1, 0, 0, 0), e(32'h80, 1, 1, 0, 1), e(32'h84, 1, 0, 0, 0)};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply(ctl[i], 32'h40, jt[i]);
      exp_q.push_back(ex[i]);
      @(negedge CLK);
      want = exp_q.pop_front();
      n_checks++;
      if (observed() !== want) begin
        n_fail++;
        $display("FAIL branch_jump[%0d]: got=%h expected=%h", i, observed(), want);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] want;
    logic [6:0]   c;
    logic [31:0]  pc;
    logic         fv;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      c  = (i >= 5 && i <= 7) ? C_STALL : C_IDLE;
      pc = (i <= 5) ? 32'(4 * i) : (i <= 8 ? 32'd20 : 32'd24);
      fv = (i != 0) && !(i >= 5 && i <= 7);
      apply(c, 32'h0, 32'h0);
      exp_q.push_back(e(pc, fv, 1'b0, 1'b0, 1'b0));
      @(negedge CLK);
      want = exp_q.pop_front();
      n_checks++;
      if (observed() !== want) begin
        n_fail++;
        $display("FAIL stall[%0d]: got=%h expected=%h", i, observed(), want);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_halt_step();
    logic [W-1:0] want;
    logic [6:0]   ctl [10];
    logic [W-1:0] ex  [10];
    ctl = '{C_JMP, C_HREQ, C_HREQ | C_RES, C_STEP, C_IDLE, C_STEP,
            C_BR | C_JMP | C_STALL, C_RES | C_STEP, C_IDLE, C_IDLE};
    ex  = '{e(32'd0, 0, 0, 0, 0),    e(32'd1024, 1, 1, 0, 0), e(32'd1028, 0, 0, 1, 0),
            e(32'd1028, 0, 0, 1, 0), e(32'd1032, 1, 0, 1, 0), e(32'd1032, 0, 0, 1, 0),
            e(32'd1036, 1, 0, 1, 0), e(32'd1036, 0, 0, 1, 0), e(32'd1036, 1, 0, 0, 0),
            e(32'd1040, 1, 0, 0, 0)};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply(ctl[i], (i == 6) ? 32'h500 : 32'h0, (i == 0) ? 32'd1024 : 32'h500);
      exp_q.push_back(ex[i]);
      @(negedge CLK);
      want = exp_q.pop_front();
      n_checks++;
      if (observed() !== want) begin
        n_fail++;
        $display("FAIL halt_step[%0d]: got=%h expected=%h", i, observed(), want);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset_override();
    logic [W-1:0] want;
    logic [6:0]   ctl [7];
    logic [W-1:0] ex  [7];
    ctl = '{C_JMP, C_HREQ, C_RST | C_STEP, C_IDLE, C_BR | C_RST, C_IDLE, C_IDLE};
    ex  = '{e(32'd0, 0, 0, 0, 0), e(32'd1024, 1, 1, 0, 0), e(32'd1028, 0, 0, 1, 0),
            e(32'd0, 0, 0, 0, 0), e(32'd4, 1, 0, 0, 0), e(32'd0, 0, 0, 0, 0),
            e(32'd4, 1, 0, 0, 0)};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(ctl[i], 32'h203, 32'd1024);
      exp_q.push_back(ex[i]);
      @(negedge CLK);
      want = exp_q.pop_front();
      n_checks++;
      if (observed() !== want) begin
        n_fail++;
        $display("FAIL reset_override[%0d]: got=%h expected=%h", i, observed(), want);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] want;
    logic [W-1:0] ex [4];
    ex = '{e(32'd0, 0, 0, 0, 0), e(32'hFFFF_FFFC, 1, 1, 0, 0),
           e(32'h0000_0000, 1, 0, 0, 0), e(32'h0000_0004, 1, 0, 0, 0)};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply((i == 0) ? C_JMP : C_IDLE, 32'h0, 32'hFFFF_FFFC);
      exp_q.push_back(ex[i]);
      @(negedge CLK);
      want = exp_q.pop_front();
      n_checks++;
      if (observed() !== want) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got=%h expected=%h", i, observed(), want);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_random_stall();
    logic [W-1:0] want;
    logic [31:0]  pc;
    logic         s;
    do_reset();
    apply(C_IDLE, 32'h0, 32'h0);
    @(posedge CLK);
    #1;
    pc = 32'd4;
    for (int i = 0; i < 20; i++) begin
      s = 1'($urandom_range(0, 1));
      apply(s ? C_STALL : C_IDLE, 32'h0, 32'h0);
      exp_q.push_back(e(pc, !s, 1'b0, 1'b0, 1'b0));
      @(negedge CLK);
      want = exp_q.pop_front();
      n_checks++;
      if (observed() !== want) begin
        n_fail++;
        $display("FAIL random_stall[%0d]: got=%h expected=%h", i, observed(), want);
      end
      if (!s) pc = pc + 32'd4;
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    @(posedge CLK);
    #1;
    test_reset();
    test_branch_stall();
    test_branch_jump();
    test_stall();
    test_halt_step();
    test_reset_override();
    test_wrap();
    test_random_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter register and decides its next value every cycle.
- Sources, in fixed priority: sequential increment, branch redirect, jump redirect, hazard stall, halt and debug single-step.
- Sits between the fetch stage (instruction memory address) and the decode/execute stages, which supply redirects and stalls.
- Issues a one-cycle flush to the IF/ID register on every redirect.

Parameters:
- WIDTH, 32, PC and target width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INC, 4, byte increment per sequential fetch.

Ports:
- CLK  in  1  single clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- STALL  in  1  hazard unit requests PC hold
- BRANCH_TAKEN  in  1  EX stage resolved taken branch
- BRANCH_TARGET  in  WIDTH  branch destination
- JUMP  in  1  ID stage jump (J/JAL/JR)
- JUMP_TARGET  in  WIDTH  jump destination
- HALT_REQ  in  1  halt instruction decoded or debugger halt
- STEP  in  1  debug single-step pulse, honoured only while halted
- RESUME  in  1  leave halt
- PC_OUT  out  WIDTH  current PC, drives instruction memory address
- PC_PLUS4  out  WIDTH  PC_OUT + INC, combinational, for link register
- FETCH_VALID  out  1  PC_OUT is a fetch to be consumed this cycle
- FLUSH  out  1  squash IF/ID contents, 1-cycle pulse
- HALTED  out  1  sequencer in HALT state
- MISALIGN  out  1  1-cycle pulse: accepted redirect target had bits [1:0] != 0

Behaviour:
- Reset (RST=1 at an edge), overriding everything, including mid-redirect or mid-step:
  - PC_OUT=RESET_PC, state=RUN.
  - FLUSH=0, MISALIGN=0, HALTED=0, FETCH_VALID=0 for the cycle after reset, then 1.
- States: RUN, HALT. One extra registered bit, `first`, suppresses FETCH_VALID in the cycle after reset.
- RUN next-PC priority, highest first:
  1. BRANCH_TAKEN -> PC=BRANCH_TARGET, FLUSH=1.
  2. JUMP -> PC=JUMP_TARGET, FLUSH=1.
  3. STALL -> PC held, FLUSH=0.
  4. else PC=PC+INC.
- Redirects beat STALL; a stall never delays a redirect.
- BRANCH_TAKEN and JUMP together: branch wins (older instruction); FLUSH=1 once.
- Redirect target alignment: bits [1:0] are forced to 0 before loading. MISALIGN pulses in the same cycle FLUSH pulses.
- Latency: redirect asserted in cycle N -> PC_OUT equals target in cycle N+1; FLUSH is registered and high in cycle N+1 only.
- Wrap-around: PC+INC is modulo 2^WIDTH. 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- HALT_REQ in RUN:
  - The PC update of that cycle (redirect, stall or increment) is applied.
  - State goes to HALT next cycle; HALTED=1 from that cycle.
- In HALT:
  - PC held; FETCH_VALID=0.
  - STALL, BRANCH_TAKEN and JUMP are ignored.
- STEP in HALT: PC=PC+INC. FETCH_VALID=1 for exactly the following cycle. State stays HALT.
- RESUME in HALT: state=RUN next cycle. FETCH_VALID=1 from that cycle, PC unchanged on the transition.
- RESUME and STEP together: RESUME wins; no extra increment.
- HALT_REQ and RESUME together while in HALT: stay in HALT.
- FETCH_VALID in RUN = !STALL | redirect | first-cycle gating. It is low during a pure stall cycle.
- PC_PLUS4 is combinational from PC_OUT in all states.

Decomposition:
- Shared package mips_pkg:
  - State encoding: RUN=1'b0, HALT=1'b1.
  - Constants: RESET_PC default, INC, alignment mask 32'hFFFF_FFFC.
- One sub-module: pc_next_mux.
  - Purely combinational priority select of next PC, plus redirect/misalign flags.
  - Reused by the verification model.
- The state register and PC register stay in pc_sequencer.

Test Plan:
- Reset then 4 idle cycles -> PC_OUT 0,4,8,12. FETCH_VALID low only in the first cycle after reset.
- Branch redirect at PC=8 with BRANCH_TARGET=32'h100 and STALL=1 in the same cycle -> next PC_OUT=32'h100, FLUSH=1 for one cycle, then 32'h104.
- BRANCH_TAKEN (target 32'h40) and JUMP (target 32'h80) together -> PC_OUT=32'h40, single FLUSH pulse; JUMP_TARGET=32'h82 alone -> PC_OUT=32'h80, MISALIGN=1.
- STALL high 3 cycles at PC=20 -> PC_OUT stays 20, FETCH_VALID=0 throughout, resumes at 24.
- HALT_REQ at PC=1024, then STEP twice, then RESUME:
  - HALTED=1 with PC=1028.
  - Each STEP gives +4 (1032, 1036), with a 1-cycle FETCH_VALID per step.
  - After RESUME, RUN continues at 1036 then 1040.
- RST asserted mid-halt and on a redirect cycle, plus PC preloaded near 32'hFFFF_FFFC:
  - Reset -> PC_OUT=0, HALTED=0, FLUSH=0.
  - Separately, 32'hFFFF_FFFC increments to 32'h0.
